// File: rtl/dma_rate_meter.sv
// DMA TX/RX throughput meter: counts TLPs and payload DWORDs per CLK_FREQ-cycle window.
// Optional peak-hold registers are enabled by defining RATE_METER_PEAK_EN.
module dma_rate_meter #(
    parameter int CLK_FREQ = 125_000_000,
    parameter int DW_INC_W = 4
) (
    input  logic                clk,
    input  logic                sys_rst,
    input  logic                soft_reset,
    input  logic                meter_en,
    input  logic                tx_pkt,
    input  logic                tx_dw_vld,
    input  logic [DW_INC_W-1:0] tx_dw_cnt,
    input  logic                rx_pkt,
    input  logic                rx_dw_vld,
    input  logic [DW_INC_W-1:0] rx_dw_cnt,
    output logic [31:0]         dma_tx_pps,
    output logic [31:0]         dma_tx_dw,
    output logic [31:0]         dma_rx_pps,
    output logic [31:0]         dma_rx_dw,
`ifdef RATE_METER_PEAK_EN
    input  logic                peak_clr,
    output logic [31:0]         dma_tx_pps_peak,
    output logic [31:0]         dma_tx_dw_peak,
    output logic [31:0]         dma_rx_pps_peak,
    output logic [31:0]         dma_rx_dw_peak,
`endif
    output logic                sec_tick
);

    localparam int PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;

    logic [PW-1:0] prescaler;
    logic [31:0]   acc_tx_pps;
    logic [31:0]   acc_tx_dw;
    logic [31:0]   acc_rx_pps;
    logic [31:0]   acc_rx_dw;

    logic          terminal;
    logic [31:0]   tx_pps_sum;
    logic [31:0]   tx_dw_sum;
    logic [31:0]   rx_pps_sum;
    logic [31:0]   rx_dw_sum;

    // Increments are small, so a carry out of bit 31 always means saturation.
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    assign terminal   = (prescaler == PW'(CLK_FREQ - 1));
    assign tx_pps_sum = sat_add(acc_tx_pps, 32'(meter_en & tx_pkt));
    assign rx_pps_sum = sat_add(acc_rx_pps, 32'(meter_en & rx_pkt));
    assign tx_dw_sum  = sat_add(acc_tx_dw, (meter_en && tx_dw_vld) ? 32'(tx_dw_cnt) : 32'd0);
    assign rx_dw_sum  = sat_add(acc_rx_dw, (meter_en && rx_dw_vld) ? 32'(rx_dw_cnt) : 32'd0);

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            prescaler  <= '0;
            acc_tx_pps <= '0;
            acc_tx_dw  <= '0;
            acc_rx_pps <= '0;
            acc_rx_dw  <= '0;
            dma_tx_pps <= '0;
            dma_tx_dw  <= '0;
            dma_rx_pps <= '0;
            dma_rx_dw  <= '0;
            sec_tick   <= 1'b0;
        end else if (soft_reset) begin
            // Restart the window; published values are deliberately left alone.
            prescaler  <= '0;
            acc_tx_pps <= '0;
            acc_tx_dw  <= '0;
            acc_rx_pps <= '0;
            acc_rx_dw  <= '0;
            sec_tick   <= 1'b0;
        end else if (terminal) begin
            // Events on the terminal cycle close out with this window.
            prescaler  <= '0;
            dma_tx_pps <= tx_pps_sum;
            dma_tx_dw  <= tx_dw_sum;
            dma_rx_pps <= rx_pps_sum;
            dma_rx_dw  <= rx_dw_sum;
            acc_tx_pps <= '0;
            acc_tx_dw  <= '0;
            acc_rx_pps <= '0;
            acc_rx_dw  <= '0;
            sec_tick   <= 1'b1;
        end else begin
            prescaler  <= prescaler + PW'(1);
            acc_tx_pps <= tx_pps_sum;
            acc_tx_dw  <= tx_dw_sum;
            acc_rx_pps <= rx_pps_sum;
            acc_rx_dw  <= rx_dw_sum;
            sec_tick   <= 1'b0;
        end
    end

`ifdef RATE_METER_PEAK_EN
    logic publish;

    function automatic logic [31:0] max32(input logic [31:0] a, input logic [31:0] b);
        return (a > b) ? a : b;
    endfunction

    assign publish = terminal && !soft_reset;

    // A clear that lands on a publish cycle restarts the peak from the new window value.
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            dma_tx_pps_peak <= '0;
            dma_tx_dw_peak  <= '0;
            dma_rx_pps_peak <= '0;
            dma_rx_dw_peak  <= '0;
        end else if (peak_clr) begin
            dma_tx_pps_peak <= publish ? tx_pps_sum : 32'd0;
            dma_tx_dw_peak  <= publish ? tx_dw_sum  : 32'd0;
            dma_rx_pps_peak <= publish ? rx_pps_sum : 32'd0;
            dma_rx_dw_peak  <= publish ? rx_dw_sum  : 32'd0;
        end else if (publish) begin
            dma_tx_pps_peak <= max32(dma_tx_pps_peak, tx_pps_sum);
            dma_tx_dw_peak  <= max32(dma_tx_dw_peak, tx_dw_sum);
            dma_rx_pps_peak <= max32(dma_rx_pps_peak, rx_pps_sum);
            dma_rx_dw_peak  <= max32(dma_rx_dw_peak, rx_dw_sum);
        end
    end
`endif

endmodule

// File: tb/tb_dma_rate_meter.sv
// Directed bench for dma_rate_meter with a 100-cycle window; peak checks need RATE_METER_PEAK_EN.
module tb_dma_rate_meter;

    logic        clk = 1'b0;
    logic        sys_rst;
    logic        soft_reset;
    logic        meter_en;
    logic        tx_pkt;
    logic        tx_dw_vld;
    logic [3:0]  tx_dw_cnt;
    logic        rx_pkt;
    logic        rx_dw_vld;
    logic [3:0]  rx_dw_cnt;
    logic [31:0] dma_tx_pps;
    logic [31:0] dma_tx_dw;
    logic [31:0] dma_rx_pps;
    logic [31:0] dma_rx_dw;
    logic        sec_tick;
`ifdef RATE_METER_PEAK_EN
    logic        peak_clr;
    logic [31:0] dma_tx_pps_peak;
    logic [31:0] dma_tx_dw_peak;
    logic [31:0] dma_rx_pps_peak;
    logic [31:0] dma_rx_dw_peak;
`endif

    int total = 0;
    int bad   = 0;
    int ph    = 0;   // prescaler value the next rising edge will see
    int ticks = 0;

    always #5 clk = ~clk;

    dma_rate_meter #(.CLK_FREQ(100), .DW_INC_W(4)) dut (
        .clk(clk), .sys_rst(sys_rst), .soft_reset(soft_reset), .meter_en(meter_en),
        .tx_pkt(tx_pkt), .tx_dw_vld(tx_dw_vld), .tx_dw_cnt(tx_dw_cnt),
        .rx_pkt(rx_pkt), .rx_dw_vld(rx_dw_vld), .rx_dw_cnt(rx_dw_cnt),
        .dma_tx_pps(dma_tx_pps), .dma_tx_dw(dma_tx_dw),
        .dma_rx_pps(dma_rx_pps), .dma_rx_dw(dma_rx_dw),
`ifdef RATE_METER_PEAK_EN
        .peak_clr(peak_clr),
        .dma_tx_pps_peak(dma_tx_pps_peak), .dma_tx_dw_peak(dma_tx_dw_peak),
        .dma_rx_pps_peak(dma_rx_pps_peak), .dma_rx_dw_peak(dma_rx_dw_peak),
`endif
        .sec_tick(sec_tick)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chk_out(input string tag, input logic [31:0] tp, input logic [31:0] td,
                           input logic [31:0] rp, input logic [31:0] rd);
        chk({tag, "_txp"}, dma_tx_pps, tp);
        chk({tag, "_txd"}, dma_tx_dw, td);
        chk({tag, "_rxp"}, dma_rx_pps, rp);
        chk({tag, "_rxd"}, dma_rx_dw, rd);
    endtask

    task automatic step();
        int nph;
        nph = (soft_reset || sys_rst) ? 0 : (ph + 1) % 100;
        @(negedge clk);
        ph = nph;
        if (sec_tick) ticks++;
    endtask

    task automatic clr_in();
        soft_reset = 1'b0;
        tx_pkt = 1'b0; tx_dw_vld = 1'b0; tx_dw_cnt = 4'd0;
        rx_pkt = 1'b0; rx_dw_vld = 1'b0; rx_dw_cnt = 4'd0;
`ifdef RATE_METER_PEAK_EN
        peak_clr = 1'b0;
`endif
    endtask

    task automatic pulse_tx(input int n, input logic [3:0] cnt);
        for (int i = 0; i < n; i++) begin
            tx_pkt = 1'b1; tx_dw_vld = 1'b1; tx_dw_cnt = cnt;
            step();
        end
        clr_in();
    endtask

    task automatic idle_to(input int p);
        clr_in();
        while (ph != p) step();
    endtask

    // Runs through the terminal cycle; sec_tick and new outputs are then visible.
    task automatic finish_window();
        idle_to(99);
        step();
    endtask

    initial begin
        sys_rst = 1'b1;
        meter_en = 1'b1;
        clr_in();
        step();
        step();
        chk_out("rst", 0, 0, 0, 0);
        chk("rst_tick", 32'(sec_tick), 0);
        sys_rst = 1'b0;
        ph = 0;

        // Window 1: 10 TX packets of 4 DW; invalid DW counts ignored.
        pulse_tx(10, 4'd4);
        tx_dw_cnt = 4'd15; rx_dw_cnt = 4'd7;
        step();
        clr_in();
        chk_out("w1_mid", 0, 0, 0, 0);
        finish_window();
        chk("w1_tick", 32'(sec_tick), 1);
        chk_out("w1", 10, 40, 0, 0);
        step();
        chk("w1_tick_off", 32'(sec_tick), 0);
        chk_out("w1_hold", 10, 40, 0, 0);

        // Window 2: RX event exactly on the terminal cycle.
        idle_to(99);
        rx_pkt = 1'b1; rx_dw_vld = 1'b1; rx_dw_cnt = 4'd8;
        step();
        clr_in();
        chk("w2_tick", 32'(sec_tick), 1);
        chk_out("w2", 0, 0, 1, 8);

        // Window 3: both paths active on every cycle.
        for (int i = 0; i < 100; i++) begin
            tx_pkt = 1'b1; tx_dw_vld = 1'b1; tx_dw_cnt = 4'd15;
            rx_pkt = 1'b1; rx_dw_vld = 1'b1; rx_dw_cnt = 4'd1;
            step();
        end
        clr_in();
        chk("w3_tick", 32'(sec_tick), 1);
        chk_out("w3", 100, 1500, 100, 100);

        // Window 4: metering disabled, totals still published.
        meter_en = 1'b0;
        pulse_tx(20, 4'd9);
        finish_window();
        meter_en = 1'b1;
        chk("w4_tick", 32'(sec_tick), 1);
        chk_out("w4", 0, 0, 0, 0);

        // Window 5: saturation of the TX DWORD accumulator.
        idle_to(10);
        force dut.acc_tx_dw = 32'hFFFF_FFF0;
        step();
        release dut.acc_tx_dw;
        for (int i = 0; i < 2; i++) begin
            tx_dw_vld = 1'b1; tx_dw_cnt = 4'd15;
            step();
        end
        clr_in();
        finish_window();
        chk_out("w5_sat", 0, 32'hFFFF_FFFF, 0, 0);

        // Window 6: soft_reset mid-window discards earlier packets.
        pulse_tx(5, 4'd2);
        idle_to(50);
        soft_reset = 1'b1; tx_pkt = 1'b1;
        step();
        clr_in();
        chk("sr_ph", 32'(ph), 0);
        chk("sr_tick", 32'(sec_tick), 0);
        chk_out("sr_hold", 0, 32'hFFFF_FFFF, 0, 0);
        ticks = 0;
        pulse_tx(3, 4'd0);
        finish_window();
        chk("sr_ticks", 32'(ticks), 1);
        chk("sr_tick_end", 32'(sec_tick), 1);
        chk_out("sr_win", 3, 0, 0, 0);

        // soft_reset on the terminal cycle: no publish, no tick.
        pulse_tx(4, 4'd1);
        idle_to(99);
        soft_reset = 1'b1; tx_pkt = 1'b1;
        step();
        clr_in();
        chk("srt_tick", 32'(sec_tick), 0);
        chk_out("srt_hold", 3, 0, 0, 0);
        finish_window();
        chk_out("srt_next", 0, 0, 0, 0);

        // Mid-window sys_rst loses the partial window.
        pulse_tx(4, 4'd3);
        sys_rst = 1'b1;
        step();
        sys_rst = 1'b0;
        chk_out("mrst", 0, 0, 0, 0);
        finish_window();
        chk_out("mrst_win", 0, 0, 0, 0);

`ifdef RATE_METER_PEAK_EN
        pulse_tx(7, 4'd1);
        finish_window();
        chk("pk_w7", dma_tx_pps_peak, 7);
        pulse_tx(3, 4'd1);
        finish_window();
        chk("pk_w3", dma_tx_pps_peak, 7);
        pulse_tx(9, 4'd1);
        finish_window();
        chk("pk_w9", dma_tx_pps_peak, 9);
        chk("pk_dw9", dma_tx_dw_peak, 9);
        idle_to(20);
        peak_clr = 1'b1;
        step();
        clr_in();
        chk("pk_clr", dma_tx_pps_peak, 0);
        chk("pk_clr_dw", dma_tx_dw_peak, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
